pmp_checker: RTL and testbench

PMP_CHECKER -- requirements
Module: pmp_checker

---
 rtl/pmp_checker.sv | 197 +++++++++++++++++++
 tb/tb_pmp_checker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_checker.sv
// rtl/pmp_checker.sv - sequential PMP access checker, one entry per cycle
//
// Ports:
//   clock, reset              : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready       : access request handshake (ready only when idle)
//   req_addr, req_type        : byte address; 00 read, 01 write, 10 execute, 11 reserved
//   priv_mode                 : 00 M, 01 S, 11 U, 10 treated as U
//   pmpcfg0..3_data           : live entry configs, byte j of word N is entry 4N+j
//   pmpaddr0..15_data         : live entry addresses (address bits [33:2])
//   resp_valid/resp_ready     : response handshake
//   resp_allow, resp_matched, resp_idx : verdict, match flag, matching entry
`timescale 1ns/1ps
module pmp_checker (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_type,
    input  logic [1:0]  priv_mode,
    input  logic [31:0] pmpcfg0_data,
    input  logic [31:0] pmpcfg1_data,
    input  logic [31:0] pmpcfg2_data,
    input  logic [31:0] pmpcfg3_data,
    input  logic [31:0] pmpaddr0_data,
    input  logic [31:0] pmpaddr1_data,
    input  logic [31:0] pmpaddr2_data,
    input  logic [31:0] pmpaddr3_data,
    input  logic [31:0] pmpaddr4_data,
    input  logic [31:0] pmpaddr5_data,
    input  logic [31:0] pmpaddr6_data,
    input  logic [31:0] pmpaddr7_data,
    input  logic [31:0] pmpaddr8_data,
    input  logic [31:0] pmpaddr9_data,
    input  logic [31:0] pmpaddr10_data,
    input  logic [31:0] pmpaddr11_data,
    input  logic [31:0] pmpaddr12_data,
    input  logic [31:0] pmpaddr13_data,
    input  logic [31:0] pmpaddr14_data,
    input  logic [31:0] pmpaddr15_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_allow,
    output logic        resp_matched,
    output logic [3:0]  resp_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  type_q, type_d;
    logic [1:0]  priv_q, priv_d;
    logic        allow_q, allow_d;
    logic        matched_q, matched_d;
    logic [3:0]  ridx_q, ridx_d;

    logic [31:0]  pa [16];
    logic [127:0] cfg_flat;

    assign pa[0]  = pmpaddr0_data;
    assign pa[1]  = pmpaddr1_data;
    assign pa[2]  = pmpaddr2_data;
    assign pa[3]  = pmpaddr3_data;
    assign pa[4]  = pmpaddr4_data;
    assign pa[5]  = pmpaddr5_data;
    assign pa[6]  = pmpaddr6_data;
    assign pa[7]  = pmpaddr7_data;
    assign pa[8]  = pmpaddr8_data;
    assign pa[9]  = pmpaddr9_data;
    assign pa[10] = pmpaddr10_data;
    assign pa[11] = pmpaddr11_data;
    assign pa[12] = pmpaddr12_data;
    assign pa[13] = pmpaddr13_data;
    assign pa[14] = pmpaddr14_data;
    assign pa[15] = pmpaddr15_data;
    assign cfg_flat = {pmpcfg3_data, pmpcfg2_data, pmpcfg1_data, pmpcfg0_data};

    // Current entry, read live from the register inputs every scan cycle.
    logic [7:0]  cfg_cur;
    logic [31:0] upper, lower, wa, napot_mask;
    logic        hit, is_m, allow_hit, allow_miss;

    assign cfg_cur = cfg_flat[{idx_q, 3'b000} +: 8];
    assign upper   = pa[idx_q];
    assign lower   = (idx_q == 4'd0) ? 32'd0 : pa[idx_q - 4'd1];
    assign wa      = {2'b00, addr_q[31:2]};
    // Bits [t:0] set, where t is the trailing-ones count; all ones covers everything.
    assign napot_mask = upper ^ (upper + 32'd1);
    assign is_m    = (priv_q == 2'b00);

    always_comb begin
        hit = 1'b0;
        case (cfg_cur[4:3])
            2'b01:   hit = (lower < upper) && (wa >= lower) && (wa < upper);
            2'b10:   hit = (wa == upper);
            2'b11:   hit = (((wa ^ upper) & ~napot_mask) == 32'd0);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        allow_hit = 1'b0;
        if (type_q == 2'b11) begin
            allow_hit = 1'b0;
        end else if (is_m && !cfg_cur[7]) begin
            allow_hit = 1'b1;
        end else begin
            case (type_q)
                2'b00:   allow_hit = cfg_cur[0];
                // W without R is reserved: treat as no read/write access.
                2'b01:   allow_hit = cfg_cur[1] & cfg_cur[0];
                2'b10:   allow_hit = cfg_cur[2];
                default: allow_hit = 1'b0;
            endcase
        end
    end

    assign allow_miss = is_m && (type_q != 2'b11);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        type_d    = type_q;
        priv_d    = priv_q;
        allow_d   = allow_q;
        matched_d = matched_q;
        ridx_d    = ridx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    type_d  = req_type;
                    priv_d  = priv_mode;
                    idx_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    matched_d = 1'b1;
                    ridx_d    = idx_q;
                    allow_d   = allow_hit;
                    state_d   = RESP;
                end else if (idx_q == 4'd15) begin
                    matched_d = 1'b0;
                    ridx_d    = 4'd0;
                    allow_d   = allow_miss;
                    state_d   = RESP;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            addr_q    <= 32'd0;
            type_q    <= 2'd0;
            priv_q    <= 2'd0;
            allow_q   <= 1'b0;
            matched_q <= 1'b0;
            ridx_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            priv_q    <= priv_d;
            allow_q   <= allow_d;
            matched_q <= matched_d;
            ridx_q    <= ridx_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_allow   = allow_q;
    assign resp_matched = matched_q;
    assign resp_idx     = ridx_q;

endmodule

// File: tb/tb_pmp_checker.sv
// tb/tb_pmp_checker.sv - directed self-checking bench for pmp_checker
`timescale 1ns/1ps
module tb_pmp_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_type = 2'd0;
    logic [1:0]  priv_mode = 2'd0;
    logic [31:0] pmpcfg [4];
    logic [31:0] pmpaddr [16];
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_allow;
    logic        resp_matched;
    logic [3:0]  resp_idx;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pmp_checker dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_type(req_type), .priv_mode(priv_mode),
        .pmpcfg0_data(pmpcfg[0]), .pmpcfg1_data(pmpcfg[1]),
        .pmpcfg2_data(pmpcfg[2]), .pmpcfg3_data(pmpcfg[3]),
        .pmpaddr0_data(pmpaddr[0]), .pmpaddr1_data(pmpaddr[1]),
        .pmpaddr2_data(pmpaddr[2]), .pmpaddr3_data(pmpaddr[3]),
        .pmpaddr4_data(pmpaddr[4]), .pmpaddr5_data(pmpaddr[5]),
        .pmpaddr6_data(pmpaddr[6]), .pmpaddr7_data(pmpaddr[7]),
        .pmpaddr8_data(pmpaddr[8]), .pmpaddr9_data(pmpaddr[9]),
        .pmpaddr10_data(pmpaddr[10]), .pmpaddr11_data(pmpaddr[11]),
        .pmpaddr12_data(pmpaddr[12]), .pmpaddr13_data(pmpaddr[13]),
        .pmpaddr14_data(pmpaddr[14]), .pmpaddr15_data(pmpaddr[15]),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_allow(resp_allow), .resp_matched(resp_matched), .resp_idx(resp_idx)
    );

    task automatic clear_cfg();
        for (int i = 0; i < 4; i++) pmpcfg[i] = 32'd0;
        for (int i = 0; i < 16; i++) pmpaddr[i] = 32'd0;
    endtask

    // Presents one request for exactly one clock edge; returns at the negedge after acceptance.
    task automatic start_req(input logic [31:0] a, input logic [1:0] t, input logic [1:0] p);
        @(negedge clock);
        req_addr = a; req_type = t; priv_mode = p; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Counts edges after acceptance until resp_valid is seen (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_cfg();
        repeat (2) @(negedge clock);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_allow !== 1'b0) begin errors++; $display("FAIL reset_resp_allow got %b want 0", resp_allow); end
        checks++; if (resp_matched !== 1'b0) begin errors++; $display("FAIL reset_resp_matched got %b want 0", resp_matched); end
        checks++; if (resp_idx !== 4'd0) begin errors++; $display("FAIL reset_resp_idx got %0d want 0", resp_idx); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_no_match();
        logic [31:0] va [4];
        logic [1:0]  vt [4];
        logic [1:0]  vp [4];
        logic        ea [4];
        int lat;
        va = '{32'h1000, 32'h1000, 32'h1000, 32'h1000};
        vt = '{2'b00, 2'b00, 2'b00, 2'b11};
        vp = '{2'b00, 2'b11, 2'b01, 2'b00};
        ea = '{1'b1, 1'b0, 1'b0, 1'b0};
        clear_cfg();
        for (int i = 0; i < 4; i++) begin
            start_req(va[i], vt[i], vp[i]);
            wait_resp(lat);
            checks++; if (lat !== 16) begin errors++; $display("FAIL nomatch_lat[%0d] got %0d want 16", i, lat); end
            checks++; if (resp_matched !== 1'b0) begin errors++; $display("FAIL nomatch_matched[%0d] got %b want 0", i, resp_matched); end
            checks++; if (resp_idx !== 4'd0) begin errors++; $display("FAIL nomatch_idx[%0d] got %0d want 0", i, resp_idx); end
            checks++; if (resp_allow !== ea[i]) begin errors++; $display("FAIL nomatch_allow[%0d] got %b want %b", i, resp_allow, ea[i]); end
            finish_resp();
        end
    endtask

    task automatic test_na4();
        logic [31:0] va [5];
        logic [1:0]  vt [5];
        logic [1:0]  vp [5];
        int          el [5];
        logic        em [5];
        logic        ea [5];
        int lat;
        va = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        vt = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        vp = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
        el = '{1, 1, 1, 1, 16};
        em = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ea = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        clear_cfg();
        pmpaddr[0] = 32'h400;
        pmpcfg[0]  = 32'h0000_0011;
        for (int i = 0; i < 5; i++) begin
            start_req(va[i], vt[i], vp[i]);
            wait_resp(lat);
            checks++; if (lat !== el[i]) begin errors++; $display("FAIL na4_lat[%0d] got %0d want %0d", i, lat, el[i]); end
            checks++; if (resp_matched !== em[i]) begin errors++; $display("FAIL na4_matched[%0d] got %b want %b", i, resp_matched, em[i]); end
            checks++; if (resp_idx !== 4'd0) begin errors++; $display("FAIL na4_idx[%0d] got %0d want 0", i, resp_idx); end
            checks++; if (resp_allow !== ea[i]) begin errors++; $display("FAIL na4_allow[%0d] got %b want %b", i, resp_allow, ea[i]); end
            finish_resp();
        end
    endtask

    task automatic test_tor();
        logic [31:0] va [6];
        logic [1:0]  vt [6];
        int          el [6];
        logic        em [6];
        logic        ea [6];
        int lat;
        va = '{32'h400, 32'h7FC, 32'h800, 32'h3FC, 32'h400, 32'h400};
        vt = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
        el = '{3, 3, 16, 16, 3, 16};
        em = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ea = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        clear_cfg();
        pmpaddr[1] = 32'h100;
        pmpaddr[2] = 32'h200;
        pmpcfg[0]  = 32'h000C_0000;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) pmpaddr[1] = 32'h300;
            start_req(va[i], vt[i], 2'b01);
            wait_resp(lat);
            checks++; if (lat !== el[i]) begin errors++; $display("FAIL tor_lat[%0d] got %0d want %0d", i, lat, el[i]); end
            checks++; if (resp_matched !== em[i]) begin errors++; $display("FAIL tor_matched[%0d] got %b want %b", i, resp_matched, em[i]); end
            checks++; if (resp_idx !== (em[i] ? 4'd2 : 4'd0)) begin errors++; $display("FAIL tor_idx[%0d] got %0d", i, resp_idx); end
            checks++; if (resp_allow !== ea[i]) begin errors++; $display("FAIL tor_allow[%0d] got %b want %b", i, resp_allow, ea[i]); end
            finish_resp();
        end
    endtask

    task automatic test_napot();
        logic [31:0] va [8];
        logic [1:0]  vt [8];
        logic [1:0]  vp [8];
        logic        em [8];
        logic        ea [8];
        int lat;
        va = '{32'h400, 32'h400, 32'hFFC, 32'h1000, 32'hDEADBEEC, 32'h10, 32'h10, 32'h10};
        vt = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        vp = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10};
        em = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ea = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        clear_cfg();
        pmpaddr[3] = 32'h0000_01FF;
        pmpcfg[0]  = 32'h9B00_0000;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) pmpaddr[3] = 32'hFFFF_FFFF;
            if (i == 5) pmpcfg[0] = 32'h1A00_0000;
            start_req(va[i], vt[i], vp[i]);
            wait_resp(lat);
            checks++; if (lat !== (em[i] ? 4 : 16)) begin errors++; $display("FAIL napot_lat[%0d] got %0d", i, lat); end
            checks++; if (resp_matched !== em[i]) begin errors++; $display("FAIL napot_matched[%0d] got %b want %b", i, resp_matched, em[i]); end
            checks++; if (resp_idx !== (em[i] ? 4'd3 : 4'd0)) begin errors++; $display("FAIL napot_idx[%0d] got %0d", i, resp_idx); end
            checks++; if (resp_allow !== ea[i]) begin errors++; $display("FAIL napot_allow[%0d] got %b want %b", i, resp_allow, ea[i]); end
            finish_resp();
        end
    endtask

    task automatic test_overlap_hold();
        int lat;
        int seen;
        clear_cfg();
        pmpaddr[1] = 32'h800;
        pmpaddr[5] = 32'h800;
        pmpcfg[0]  = 32'h0000_1100;
        pmpcfg[1]  = 32'h0000_1100;
        start_req(32'h2000, 2'b00, 2'b11);
        wait_resp(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL overlap_lat got %0d want 2", lat); end
        checks++; if (resp_idx !== 4'd1) begin errors++; $display("FAIL overlap_idx got %0d want 1", resp_idx); end
        req_valid = 1'b1;
        req_addr  = 32'h0;
        pmpcfg[0] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (resp_valid !== 1'b1 || resp_idx !== 4'd1 || resp_allow !== 1'b1
                || resp_matched !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got v=%b idx=%0d a=%b m=%b rdy=%b want v=1 idx=1 a=1 m=1 rdy=0",
                         i, resp_valid, resp_idx, resp_allow, resp_matched, req_ready);
            end
        end
        req_valid = 1'b0;
        finish_resp();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL after_handshake got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready); end
        seen = 0;
        repeat (20) begin @(negedge clock); if (resp_valid === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ignored_req got %0d resp cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int seen;
        clear_cfg();
        start_req(32'h1000, 2'b00, 2'b00);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_allow !== 1'b0
            || resp_matched !== 1'b0 || resp_idx !== 4'd0) begin
            errors++;
            $display("FAIL midscan_reset got v=%b rdy=%b a=%b m=%b idx=%0d want v=0 rdy=1 a=0 m=0 idx=0",
                     resp_valid, req_ready, resp_allow, resp_matched, resp_idx);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin @(negedge clock); if (resp_valid === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL aborted_resp got %0d resp cycles want 0", seen); end
        start_req(32'h1000, 2'b00, 2'b00);
        wait_resp(lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL post_reset_lat got %0d want 16", lat); end
        checks++; if (resp_allow !== 1'b1) begin errors++; $display("FAIL post_reset_allow got %b want 1", resp_allow); end
        finish_resp();
    endtask

    initial begin
        clear_cfg();
        test_reset();
        test_no_match();
        test_na4();
        test_tor();
        test_napot();
        test_overlap_hold();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
